pulse_divider_prog: RTL and testbench
=====================================

// Module: pulse_divider_prog
// PURPOSE
//   Programmable pulse generator and clock divider. Successor to the fixed divide-by-3 toggler.
//   Adds runtime-loadable divisor, four output modes (toggle, strobe, PWM, one-shot burst),
//   enable control and glitch-free reconfiguration at period boundaries.
//   Feeds slow enables and test waveforms to Guia-level benches and downstream counters.
// PARAMETERS
//   WIDTH      8   width of divisor, duty and internal counters
//   DIV_RESET  3   divisor loaded at reset (must be >= 1)
// PORTS
//   clock    in   1      system clock; all logic on posedge
//   reset    in   1      synchronous, active-low reset
//   enable   in   1      1 = run generator, 0 = return to IDLE
//   load     in   1      1-cycle strobe: capture mode_in/div_in/high_in
//   mode_in  in   2      00 TOGGLE, 01 STROBE, 10 PWM, 11 ONESHOT
//   div_in   in   WIDTH  period in clock cycles (0 illegal)
//   high_in  in   WIDTH  PWM high cycles / ONESHOT tick count
//   signal   out  1      main waveform (registered)
//   tick     out  1      1-cycle pulse on every period wrap (registered)
//   busy     out  1      1 while state != IDLE
//   done     out  1      ONESHOT burst finished; held until enable=0
//   cfg_err  out  1      1-cycle pulse: load rejected (div_in == 0)
// BEHAVIOUR
//   Reset (reset==0 at posedge): state IDLE, cnt=0, burst=0, signal=0, tick=0, done=0, cfg_err=0,
//     cur_div=DIV_RESET, cur_high=1, cur_mode=00, pending flag cleared. Reset overrides all inputs.
//   States: IDLE, RUN, DONE.
//     IDLE -> RUN on posedge with enable=1; cnt=0; signal=1 if PWM and cur_high>0, else 0.
//       If cur_mode=ONESHOT and cur_high=0: IDLE -> DONE directly, done=1.
//     RUN: each posedge, if cnt==cur_div-1 then cnt=0 (wrap) else cnt=cnt+1.
//     RUN/DONE -> IDLE on posedge with enable=0; signal=0, tick=0, done=0, cnt=0, burst=0.
//   Modes (all in RUN):
//     TOGGLE: signal inverts on each wrap edge; period 2*cur_div. div=3 -> first rise 3 cycles after RUN.
//     STROBE: signal = tick. div=1 -> signal constant 1.
//     PWM: signal = (new cnt < cur_high) on every edge. high=0 -> always 0; high>=div -> always 1.
//     ONESHOT: tick/signal pulse on each wrap; burst++. When burst reaches cur_high -> DONE.
//       DONE: signal=0, tick=0, done=1, counter frozen.
//   tick: high for exactly the cycle after a wrap edge, in every mode; 0 in IDLE/DONE.
//   Load:
//     div_in==0: nothing captured; cfg_err=1 the next cycle.
//     IDLE or DONE: cur_* updated on the load edge; a pending set is overwritten and cleared.
//     RUN: values go to pending registers (a later load overwrites them).
//       Pending values are applied on the next wrap edge; cnt restarts at 0 with the new values.
//       TOGGLE keeps the current signal level across the swap.
//       Mode change on swap: signal is recomputed for the new mode, burst=0.
//     RUN -> IDLE with pending set: pending is applied on that edge.
//     load and wrap on the same edge: the current period ends with the old values;
//       the new values are pending until the following wrap.
//   Widths: cnt, burst are WIDTH bits, unsigned compare; no overflow is possible since cnt < cur_div.
// TESTING
//   1 Reset, load div=3 mode=00, enable=1 for 30 cycles -> signal period 6 (3 high/3 low); tick every 3rd cycle.
//   2 PWM div=5 high=2 -> signal 1,1,0,0,0 repeating.
//     Load high=7 mid-period -> after the next wrap, signal is constant 1.
//   3 ONESHOT div=4 high=3 -> 3 ticks spaced 4 cycles apart, then done=1, busy=1.
//     Drop enable -> done=0 and busy=0 the next cycle.
//   4 In RUN with div=8, load div=2 at cnt=3 -> cnt runs to 7, wraps; then the period is 2.
//     load div=0 -> cfg_err 1 cycle, period unchanged.
//   5 reset=0 asserted mid-PWM while load=1 -> all outputs 0 next cycle, cur_div=3, load ignored.
//   6 STROBE div=1 -> signal and tick constant 1 while enabled; enable=0 -> both 0 the next cycle.

Source files
------------

// File: rtl/pulse_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_divider_prog
//  Purpose  : Programmable pulse generator / clock divider with four output
//             modes (toggle, strobe, PWM, one-shot burst), enable control and
//             glitch-free reconfiguration at period boundaries.
//  Ports    : clock    - system clock, all logic on posedge
//             reset    - synchronous, active-low reset
//             enable   - 1 = run generator, 0 = return to IDLE
//             load     - 1-cycle strobe capturing mode_in / div_in / high_in
//             mode_in  - 00 TOGGLE, 01 STROBE, 10 PWM, 11 ONESHOT
//             div_in   - period in clock cycles (0 is rejected)
//             high_in  - PWM high cycles / ONESHOT tick count
//             signal   - main waveform (registered)
//             tick     - 1-cycle pulse after every period wrap (registered)
//             busy     - 1 while the generator is not IDLE
//             done     - ONESHOT burst finished, held until enable drops
//             cfg_err  - 1-cycle pulse when a load is rejected (div_in == 0)
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_divider_prog #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             signal,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [1:0]       c_MODE_TOGGLE  = 2'b00;
    localparam logic [1:0]       c_MODE_STROBE  = 2'b01;
    localparam logic [1:0]       c_MODE_PWM     = 2'b10;
    localparam logic [1:0]       c_MODE_ONESHOT = 2'b11;
    localparam logic [WIDTH-1:0] c_ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO         = '0;
    localparam logic [WIDTH-1:0] c_DIV_RESET    = WIDTH'(DIV_RESET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_burst;
    logic             r_signal;
    logic             r_tick;
    logic             r_done;
    logic             r_cfg_err;

    // Active configuration
    logic [1:0]       r_cur_mode;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_cur_high;

    // Configuration waiting for the next period boundary
    logic             r_pend_valid;
    logic [1:0]       r_pend_mode;
    logic [WIDTH-1:0] r_pend_div;
    logic [WIDTH-1:0] r_pend_high;

    logic             w_load_ok;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [1:0]       w_eff_mode;
    logic [WIDTH-1:0] w_eff_high;
    logic [1:0]       w_nxt_mode;
    logic [WIDTH-1:0] w_nxt_high;
    logic             w_mode_chg;
    logic             w_burst_done;

    assign w_load_ok  = load && (div_in != c_ZERO);
    // cur_div is never 0, so cnt < cur_div and the subtraction cannot wrap.
    assign w_wrap     = (r_cnt == (r_cur_div - c_ONE));
    assign w_cnt_inc  = r_cnt + c_ONE;

    // Configuration seen when starting from IDLE: a load on the same edge wins.
    assign w_eff_mode = w_load_ok ? mode_in : r_cur_mode;
    assign w_eff_high = w_load_ok ? high_in : r_cur_high;

    // Configuration in force after a wrap edge (pending set swapped in).
    assign w_nxt_mode = r_pend_valid ? r_pend_mode : r_cur_mode;
    assign w_nxt_high = r_pend_valid ? r_pend_high : r_cur_high;
    assign w_mode_chg = r_pend_valid && (r_pend_mode != r_cur_mode);

    // ">=" so that a swap lowering the count below the burst already emitted
    // still terminates instead of running forever.
    assign w_burst_done = (r_cur_mode == c_MODE_ONESHOT) && (r_burst >= r_cur_high);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= c_ZERO;
            r_burst      <= c_ZERO;
            r_signal     <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cur_mode   <= c_MODE_TOGGLE;
            r_cur_div    <= c_DIV_RESET;
            r_cur_high   <= c_ONE;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= c_MODE_TOGGLE;
            r_pend_div   <= c_DIV_RESET;
            r_pend_high  <= c_ONE;
        end else begin
            r_cfg_err <= load && (div_in == c_ZERO);

            case (r_state)
                S_IDLE: begin
                    r_tick       <= 1'b0;
                    r_done       <= 1'b0;
                    r_cnt        <= c_ZERO;
                    r_burst      <= c_ZERO;
                    r_pend_valid <= 1'b0;
                    if (w_load_ok) begin
                        r_cur_mode <= mode_in;
                        r_cur_div  <= div_in;
                        r_cur_high <= high_in;
                    end
                    if (enable) begin
                        if ((w_eff_mode == c_MODE_ONESHOT) && (w_eff_high == c_ZERO)) begin
                            // Empty burst: finished before it starts.
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_signal <= 1'b0;
                        end else begin
                            r_state  <= S_RUN;
                            r_signal <= (w_eff_mode == c_MODE_PWM) && (w_eff_high != c_ZERO);
                        end
                    end else begin
                        r_signal <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (!enable || w_burst_done) begin
                        // Leaving RUN: the freshest configuration becomes active,
                        // either a load on this edge or whatever was pending.
                        if (w_load_ok) begin
                            r_cur_mode <= mode_in;
                            r_cur_div  <= div_in;
                            r_cur_high <= high_in;
                        end else if (r_pend_valid) begin
                            r_cur_mode <= r_pend_mode;
                            r_cur_div  <= r_pend_div;
                            r_cur_high <= r_pend_high;
                        end
                        r_pend_valid <= 1'b0;
                        r_signal     <= 1'b0;
                        r_tick       <= 1'b0;
                        if (!enable) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                            r_cnt   <= c_ZERO;
                            r_burst <= c_ZERO;
                        end else begin
                            // Burst complete; counter stays frozen in DONE.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_wrap) begin
                        r_cnt  <= c_ZERO;
                        r_tick <= 1'b1;

                        // The period that just ended used the old values; any
                        // pending set takes over from here.
                        if (r_pend_valid) begin
                            r_cur_mode <= r_pend_mode;
                            r_cur_div  <= r_pend_div;
                            r_cur_high <= r_pend_high;
                        end
                        // A load coinciding with the wrap waits for the next one.
                        r_pend_valid <= w_load_ok;
                        if (w_load_ok) begin
                            r_pend_mode <= mode_in;
                            r_pend_div  <= div_in;
                            r_pend_high <= high_in;
                        end

                        case (w_nxt_mode)
                            c_MODE_TOGGLE: begin
                                r_signal <= ~r_signal;
                                r_burst  <= c_ZERO;
                            end
                            c_MODE_STROBE: begin
                                r_signal <= 1'b1;
                                r_burst  <= c_ZERO;
                            end
                            c_MODE_PWM: begin
                                r_signal <= (w_nxt_high != c_ZERO);
                                r_burst  <= c_ZERO;
                            end
                            c_MODE_ONESHOT: begin
                                if (w_mode_chg) begin
                                    // This wrap closed a period of another
                                    // mode; it does not count toward the burst.
                                    r_signal <= 1'b0;
                                    r_burst  <= c_ZERO;
                                end else begin
                                    r_signal <= 1'b1;
                                    r_burst  <= r_burst + c_ONE;
                                end
                            end
                        endcase
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_tick <= 1'b0;
                        if (w_load_ok) begin
                            r_pend_valid <= 1'b1;
                            r_pend_mode  <= mode_in;
                            r_pend_div   <= div_in;
                            r_pend_high  <= high_in;
                        end
                        case (r_cur_mode)
                            c_MODE_TOGGLE:  r_signal <= r_signal;
                            c_MODE_STROBE:  r_signal <= 1'b0;
                            c_MODE_PWM:     r_signal <= (w_cnt_inc < r_cur_high);
                            c_MODE_ONESHOT: r_signal <= 1'b0;
                        endcase
                    end
                end

                S_DONE: begin
                    r_signal     <= 1'b0;
                    r_tick       <= 1'b0;
                    r_pend_valid <= 1'b0;
                    if (w_load_ok) begin
                        r_cur_mode <= mode_in;
                        r_cur_div  <= div_in;
                        r_cur_high <= high_in;
                    end
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_cnt   <= c_ZERO;
                        r_burst <= c_ZERO;
                    end else begin
                        r_done <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_signal <= 1'b0;
                    r_tick   <= 1'b0;
                    r_done   <= 1'b0;
                    r_cnt    <= c_ZERO;
                    r_burst  <= c_ZERO;
                end
            endcase
        end
    end

    assign signal  = r_signal;
    assign tick    = r_tick;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pulse_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_divider_prog
//  Purpose  : Directed, table-driven bench for pulse_divider_prog. Each record
//             holds the inputs for one clock edge and the expected outputs
//             {signal, tick, busy, done, cfg_err} right after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_divider_prog;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [7:0] div_in = 8'd0;
    logic [7:0] high_in = 8'd0;
    logic       signal;
    logic       tick;
    logic       busy;
    logic       done;
    logic       cfg_err;

    always #5 clock = ~clock;

    pulse_divider_prog #(
        .WIDTH     (8),
        .DIV_RESET (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .mode_in (mode_in),
        .div_in  (div_in),
        .high_in (high_in),
        .signal  (signal),
        .tick    (tick),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       ld;
        logic [1:0] mode;
        logic [7:0] div;
        logic [7:0] high;
        logic [4:0] exp;   // {signal, tick, busy, done, cfg_err}
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [1:0] m, input logic [7:0] d, input logic [7:0] h,
                       input logic [4:0] x, input string t);
        vec_t v;
        v.rst_n = r; v.en = e; v.ld = l; v.mode = m;
        v.div = d; v.high = h; v.exp = x; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic cyc(input vec_t v);
        logic [4:0] act;
        @(negedge clock);
        reset   = v.rst_n;
        enable  = v.en;
        load    = v.ld;
        mode_in = v.mode;
        div_in  = v.div;
        high_in = v.high;
        @(posedge clock);
        #1;
        act = {signal, tick, busy, done, cfg_err};
        n_tests++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL %s: sig/tick/busy/done/err got %b expected %b", v.tag, act, v.exp);
        end
    endtask

    task automatic run(input logic r, input logic e, input logic l,
                       input logic [1:0] m, input logic [7:0] d, input logic [7:0] h,
                       input logic [4:0] x, input string t);
        vec_t v;
        v.rst_n = r; v.en = e; v.ld = l; v.mode = m;
        v.div = d; v.high = h; v.exp = x; v.tag = t;
        cyc(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset, rejected load in IDLE, TOGGLE div=3 ----
        add(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 5'b00000, "reset0");
        add(1'b0, 1'b1, 1'b1, 2'd2, 8'd9, 8'd9, 5'b00000, "reset_overrides");
        add(1'b1, 1'b0, 1'b1, 2'd0, 8'd0, 8'd5, 5'b00001, "idle_div0_err");
        add(1'b1, 1'b0, 1'b1, 2'd0, 8'd3, 8'd1, 5'b00000, "t1_load");
        for (int k = 0; k < 30; k++)
            add(1'b1, 1'b1, 1'b0, 2'd0, 8'd3, 8'd1,
                {((k / 3) % 2) == 1, (k > 0) && (k % 3 == 0), 3'b100},
                $sformatf("t1_toggle_k%0d", k));
        add(1'b1, 1'b0, 1'b0, 2'd0, 8'd3, 8'd1, 5'b00000, "t1_off");

        // ---- STROBE div=1 ----
        add(1'b1, 1'b0, 1'b1, 2'd1, 8'd1, 8'd0, 5'b00000, "t6_load");
        for (int k = 0; k < 6; k++)
            add(1'b1, 1'b1, 1'b0, 2'd1, 8'd1, 8'd0, {k > 0, k > 0, 3'b100},
                $sformatf("t6_strobe_k%0d", k));
        add(1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 8'd0, 5'b00000, "t6_off");

        // ---- PWM div=5 high=2, then high=7 loaded mid-period ----
        add(1'b1, 1'b0, 1'b1, 2'd2, 8'd5, 8'd2, 5'b00000, "t2_load");
        for (int k = 0; k < 22; k++)
            add(1'b1, 1'b1, k == 12, 2'd2, 8'd5, 8'd7,
                {(k >= 15) ? 1'b1 : ((k % 5) < 2), (k > 0) && (k % 5 == 0), 3'b100},
                $sformatf("t2_pwm_k%0d", k));

        // ---- reset mid-PWM with load asserted; default TOGGLE div=3 follows ----
        add(1'b0, 1'b1, 1'b1, 2'd3, 8'd9, 8'd4, 5'b00000, "t5_reset_load");
        for (int k = 0; k < 7; k++)
            add(1'b1, 1'b1, 1'b0, 2'd3, 8'd9, 8'd4,
                {((k / 3) % 2) == 1, (k > 0) && (k % 3 == 0), 3'b100},
                $sformatf("t5_default_k%0d", k));
        add(1'b1, 1'b0, 1'b0, 2'd0, 8'd3, 8'd1, 5'b00000, "t5_off");

        // ---- ONESHOT div=4 high=3 ----
        add(1'b1, 1'b0, 1'b1, 2'd3, 8'd4, 8'd3, 5'b00000, "t3_load");
        for (int k = 0; k < 16; k++)
            add(1'b1, 1'b1, 1'b0, 2'd3, 8'd4, 8'd3,
                (k >= 13) ? 5'b00110
                          : {(k == 4) || (k == 8) || (k == 12), (k == 4) || (k == 8) || (k == 12), 3'b100},
                $sformatf("t3_oneshot_k%0d", k));
        add(1'b1, 1'b0, 1'b0, 2'd3, 8'd4, 8'd3, 5'b00000, "t3_off");

        // ---- STROBE div=8; load div=2 at cnt=3; div=0 rejected; load on wrap ----
        add(1'b1, 1'b0, 1'b1, 2'd1, 8'd8, 8'd1, 5'b00000, "t4_load");
        for (int k = 0; k < 26; k++) begin
            logic t;
            t = (k == 8) || (k == 10) || (k == 12) || (k == 14) || (k == 16) ||
                (k == 18) || (k == 21) || (k == 24);
            add(1'b1, 1'b1, (k == 4) || (k == 13) || (k == 16), 2'd1,
                (k == 13) ? 8'd0 : ((k == 16) ? 8'd3 : 8'd2), 8'd1,
                {t, t, 2'b10, k == 13}, $sformatf("t4_swap_k%0d", k));
        end
        add(1'b1, 1'b0, 1'b0, 2'd1, 8'd2, 8'd1, 5'b00000, "t4_off");

        foreach (vecs[i]) cyc(vecs[i]);

        // ---- hand sequence: drop enable with a pending set; it must apply ----
        run(1'b1, 1'b0, 1'b1, 2'd0, 8'd4, 8'd1, 5'b00000, "h1_load_div4");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd4, 8'd1, 5'b00100, "h1_run_k0");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd4, 8'd1, 5'b00100, "h1_run_k1");
        run(1'b1, 1'b1, 1'b1, 2'd0, 8'd2, 8'd1, 5'b00100, "h1_pend_div2");
        run(1'b1, 1'b0, 1'b0, 2'd0, 8'd2, 8'd1, 5'b00000, "h1_stop");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 8'd1, 5'b00100, "h1_rerun_k0");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 8'd1, 5'b00100, "h1_rerun_k1");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 8'd1, 5'b11100, "h1_rerun_k2");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 8'd1, 5'b10100, "h1_rerun_k3");
        run(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 8'd1, 5'b01100, "h1_rerun_k4");
        run(1'b1, 1'b0, 1'b0, 2'd0, 8'd2, 8'd1, 5'b00000, "h1_off");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
